// File: rtl/decode_stage_pipe_pkg.sv
// Shared encodings for the decode stage: opcodes, instruction field positions,
// ID/EX control-bit layout and the stall FSM state type.
package decode_stage_pipe_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpHalt  = 6'h3F;

    localparam int unsigned OpMsb  = 31;
    localparam int unsigned OpLsb  = 26;
    localparam int unsigned RsMsb  = 25;
    localparam int unsigned RsLsb  = 21;
    localparam int unsigned RtMsb  = 20;
    localparam int unsigned RtLsb  = 16;
    localparam int unsigned RdMsb  = 15;
    localparam int unsigned RdLsb  = 11;
    localparam int unsigned ShMsb  = 10;
    localparam int unsigned ShLsb  = 6;
    localparam int unsigned FnMsb  = 5;
    localparam int unsigned FnLsb  = 0;
    localparam int unsigned ImmMsb = 15;
    localparam int unsigned ImmLsb = 0;

    localparam int unsigned CtrlW        = 6;
    localparam int unsigned CtrlRegWrite = 5;
    localparam int unsigned CtrlMemRead  = 4;
    localparam int unsigned CtrlMemWrite = 3;
    localparam int unsigned CtrlAluSrc   = 2;
    localparam int unsigned CtrlRegDst   = 1;
    localparam int unsigned CtrlMemToReg = 0;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StStall1 = 2'd1,
        StStall2 = 2'd2
    } stall_state_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [31:0] instr);
        instr_fields_t f;
        f.opcode = instr[OpMsb:OpLsb];
        f.rs     = instr[RsMsb:RsLsb];
        f.rt     = instr[RtMsb:RtLsb];
        f.rd     = instr[RdMsb:RdLsb];
        f.shamt  = instr[ShMsb:ShLsb];
        f.funct  = instr[FnMsb:FnLsb];
        f.imm    = instr[ImmMsb:ImmLsb];
        return f;
    endfunction

    // Branches, jumps, HALT and unknown opcodes carry no datapath control.
    function automatic logic [CtrlW-1:0] decode_ctrl(input logic [5:0] opcode);
        logic [CtrlW-1:0] c;
        c = '0;
        case (opcode)
            OpRtype: begin
                c[CtrlRegWrite] = 1'b1;
                c[CtrlRegDst]   = 1'b1;
            end
            OpAddi: begin
                c[CtrlRegWrite] = 1'b1;
                c[CtrlAluSrc]   = 1'b1;
            end
            OpLw: begin
                c[CtrlRegWrite] = 1'b1;
                c[CtrlMemRead]  = 1'b1;
                c[CtrlAluSrc]   = 1'b1;
                c[CtrlMemToReg] = 1'b1;
            end
            OpSw: begin
                c[CtrlMemWrite] = 1'b1;
                c[CtrlAluSrc]   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_regfile_bypass.sv
// Register file with three combinational read ports; r0 is hardwired to zero and
// a same-cycle write to a read index is returned on that port (write-first).
module regfile_bypass #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_we,
    input  logic [NB_REG-1:0]  i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_REG-1:0]  i_rd_addr_a,
    input  logic [NB_REG-1:0]  i_rd_addr_b,
    input  logic [NB_REG-1:0]  i_rd_addr_c,
    output logic [NB_DATA-1:0] o_rd_data_a,
    output logic [NB_DATA-1:0] o_rd_data_b,
    output logic [NB_DATA-1:0] o_rd_data_c
);

    localparam int unsigned NumRegs = 2 ** NB_REG;

    logic [NB_DATA-1:0] regs_q [NumRegs];
    logic [NB_REG-1:0]  rd_addr [3];
    logic [NB_DATA-1:0] rd_data [3];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (i_we && (i_wr_addr != '0)) begin
            regs_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign rd_addr[0] = i_rd_addr_a;
    assign rd_addr[1] = i_rd_addr_b;
    assign rd_addr[2] = i_rd_addr_c;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end else if (i_we && (i_wr_addr == rd_addr[p])) begin
                rd_data[p] = i_wr_data;
            end else begin
                rd_data[p] = regs_q[rd_addr[p]];
            end
        end
    end

    assign o_rd_data_a = rd_data[0];
    assign o_rd_data_b = rd_data[1];
    assign o_rd_data_c = rd_data[2];

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS-style ID stage: decode, register read, early branch/jump resolution,
// hazard stall FSM and the ID/EX pipeline register.
module decode_stage_pipe #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [31:0]        i_instruction,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic               i_wb_we,
    input  logic [NB_REG-1:0]  i_wb_reg,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_ex_reg_write,
    input  logic               i_ex_mem_read,
    input  logic [NB_REG-1:0]  i_ex_dst,
    input  logic               i_fwd_a,
    input  logic               i_fwd_b,
    input  logic [NB_DATA-1:0] i_fwd_data,
    input  logic [NB_REG-1:0]  i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic               o_pc_write,
    output logic               o_ifid_write,
    output logic               o_flush,
    output logic [ADDR_W-1:0]  o_pc_src,
    output logic               o_valid,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [NB_REG-1:0]  o_shamt,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_DATA-1:0] o_imm,
    output logic [5:0]         o_funct,
    output logic [5:0]         o_ctrl,
    output logic               o_halt
);

    import decode_stage_pipe_pkg::*;

    instr_fields_t      fields;
    logic [NB_REG-1:0]  rs_idx, rt_idx, rd_idx, sh_idx;
    logic [NB_DATA-1:0] rf_a, rf_b, cmp_a, cmp_b, imm_ext;
    logic [ADDR_W-1:0]  br_target, jump_target;
    logic               is_beq, is_bne, is_branch, is_jump, is_halt, uses_regs;
    logic               ex_hit, load_use, branch_alu, branch_load, stall_req;
    logic               active, taken, issue;

    stall_state_e       state_q, state_d;
    logic               halt_q, halt_d;

    logic               valid_q;
    logic [CtrlW-1:0]   ctrl_q;
    logic [NB_REG-1:0]  rs_q, rt_q, rd_q, sh_q;
    logic [NB_DATA-1:0] data_a_q, data_b_q, imm_q;
    logic [5:0]         funct_q;

    assign fields  = split_instr(i_instruction);
    assign rs_idx  = NB_REG'(fields.rs);
    assign rt_idx  = NB_REG'(fields.rt);
    assign rd_idx  = NB_REG'(fields.rd);
    assign sh_idx  = NB_REG'(fields.shamt);
    assign imm_ext = {{(NB_DATA - 16){fields.imm[15]}}, fields.imm};

    regfile_bypass #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG)
    ) u_regfile (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_we        (i_wb_we),
        .i_wr_addr   (i_wb_reg),
        .i_wr_data   (i_wb_data),
        .i_rd_addr_a (rs_idx),
        .i_rd_addr_b (rt_idx),
        .i_rd_addr_c (i_dbg_addr),
        .o_rd_data_a (rf_a),
        .o_rd_data_b (rf_b),
        .o_rd_data_c (o_dbg_data)
    );

    assign is_beq    = (fields.opcode == OpBeq);
    assign is_bne    = (fields.opcode == OpBne);
    assign is_jump   = (fields.opcode == OpJ);
    assign is_halt   = (fields.opcode == OpHalt);
    assign is_branch = is_beq | is_bne;
    // J and HALT reuse the rs/rt bit positions for other purposes.
    assign uses_regs = ~(is_jump | is_halt);

    assign ex_hit      = (i_ex_dst != '0) && ((i_ex_dst == rs_idx) || (i_ex_dst == rt_idx));
    assign load_use    = uses_regs & i_ex_mem_read & ex_hit;
    assign branch_alu  = is_branch & i_ex_reg_write & ~i_ex_mem_read & ex_hit;
    assign branch_load = is_branch & i_ex_mem_read & ex_hit;

    // Only a real instruction seen in RUN, before any halt, can stall, flush or issue.
    assign active    = i_valid & (state_q == StRun) & ~halt_q;
    assign stall_req = active & (load_use | branch_alu);

    assign cmp_a       = i_fwd_a ? i_fwd_data : rf_a;
    assign cmp_b       = i_fwd_b ? i_fwd_data : rf_b;
    assign br_target   = i_pc + imm_ext[ADDR_W-1:0];
    assign jump_target = i_instruction[ADDR_W-1:0];
    assign taken       = (is_beq & (cmp_a == cmp_b)) | (is_bne & (cmp_a != cmp_b)) | is_jump;

    assign issue  = active & ~stall_req & ~is_halt;
    assign halt_d = halt_q | (active & is_halt);

    // Stall FSM: state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StRun;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Stall FSM: next state. A branch waiting on a load needs the extra cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (stall_req) begin
                    state_d = branch_load ? StStall2 : StStall1;
                end
            end
            StStall2: state_d = StStall1;
            StStall1: state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // Stall FSM: outputs. A pending stall suppresses the redirect.
    always_comb begin
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_flush      = 1'b0;
        o_pc_src     = is_jump ? jump_target : br_target;
        if (!i_reset && ((state_q != StRun) || halt_q)) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end
        if (active && !stall_req && taken) begin
            o_flush = 1'b1;
        end
    end

    // ID/EX register; anything not issued becomes a bubble with zero control.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            sh_q     <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            imm_q    <= '0;
            funct_q  <= '0;
        end else begin
            valid_q  <= issue;
            ctrl_q   <= issue ? decode_ctrl(fields.opcode) : '0;
            rs_q     <= rs_idx;
            rt_q     <= rt_idx;
            rd_q     <= rd_idx;
            sh_q     <= sh_idx;
            data_a_q <= rf_a;
            data_b_q <= rf_b;
            imm_q    <= imm_ext;
            funct_q  <= fields.funct;
        end
    end

    assign o_valid  = valid_q;
    assign o_ctrl   = ctrl_q;
    assign o_rs     = rs_q;
    assign o_rt     = rt_q;
    assign o_rd     = rd_q;
    assign o_shamt  = sh_q;
    assign o_data_a = data_a_q;
    assign o_data_b = data_b_q;
    assign o_imm    = imm_q;
    assign o_funct  = funct_q;
    assign o_halt   = halt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: bypass, decode, branch/jump resolution,
// stall FSM, halt and reset behaviour, all against hand-computed values.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] instr;
    logic [9:0]  pc;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ex_reg_write, ex_mem_read;
    logic [4:0]  ex_dst;
    logic        fwd_a, fwd_b;
    logic [31:0] fwd_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        pc_write, ifid_write, flush;
    logic [9:0]  pc_src;
    logic        out_valid;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] data_a, data_b, imm;
    logic [5:0]  funct, ctrl;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] op_tbl   [4];
    logic [5:0] ctrl_tbl [4];

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_valid        (valid),
        .i_instruction  (instr),
        .i_pc           (pc),
        .i_wb_we        (wb_we),
        .i_wb_reg       (wb_reg),
        .i_wb_data      (wb_data),
        .i_ex_reg_write (ex_reg_write),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_dst       (ex_dst),
        .i_fwd_a        (fwd_a),
        .i_fwd_b        (fwd_b),
        .i_fwd_data     (fwd_data),
        .i_dbg_addr     (dbg_addr),
        .o_dbg_data     (dbg_data),
        .o_pc_write     (pc_write),
        .o_ifid_write   (ifid_write),
        .o_flush        (flush),
        .o_pc_src       (pc_src),
        .o_valid        (out_valid),
        .o_rs           (rs),
        .o_rt           (rt),
        .o_rd           (rd),
        .o_shamt        (shamt),
        .o_data_a       (data_a),
        .o_data_b       (data_b),
        .o_imm          (imm),
        .o_funct        (funct),
        .o_ctrl         (ctrl),
        .o_halt         (halt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] addr);
        return {6'h02, addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid        = 1'b0;
        instr        = 32'h0;
        pc           = 10'h0;
        wb_we        = 1'b0;
        wb_reg       = 5'd0;
        wb_data      = 32'h0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_dst       = 5'd0;
        fwd_a        = 1'b0;
        fwd_b        = 1'b0;
        fwd_data     = 32'h0;
    endtask

    task automatic ex_idle();
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_dst       = 5'd0;
    endtask

    task automatic ex_load(input logic [4:0] dst);
        ex_reg_write = 1'b1;
        ex_mem_read  = 1'b1;
        ex_dst       = dst;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_reg  = r;
        wb_data = d;
        tick();
        wb_we   = 1'b0;
    endtask

    initial begin
        idle();
        dbg_addr = 5'd0;
        rst      = 1'b1;
        op_tbl   = '{6'h23, 6'h2B, 6'h3E, 6'h08};
        ctrl_tbl = '{6'h35, 6'h0C, 6'h00, 6'h24};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_pc_write", pc_write, 1);
        check_eq("rst_ifid_write", ifid_write, 1);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_ctrl", ctrl, 0);
        check_eq("rst_halt", halt, 0);
        rst = 1'b0;

        // Write-back bypass into an ADD being decoded
        wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
        valid = 1'b1; instr = enc_r(5'd5, 5'd0, 5'd7, 6'h20);
        dbg_addr = 5'd5;
        #1;
        check_eq("dbg_bypass", dbg_data, 32'h1234);
        tick();
        idle();
        #1;
        check_eq("byp_data_a", data_a, 32'h1234);
        check_eq("byp_data_b", data_b, 32'h0);
        check_eq("byp_valid", out_valid, 1);
        check_eq("rtype_ctrl", ctrl, 6'h22);
        check_eq("rtype_rs", rs, 5);
        check_eq("rtype_rd", rd, 7);
        check_eq("rtype_funct", funct, 6'h20);
        check_eq("dbg_stored", dbg_data, 32'h1234);

        // r0 ignores writes; load operands for later tests
        wb_write(5'd0, 32'hDEAD);
        dbg_addr = 5'd0;
        #1;
        check_eq("r0_zero", dbg_data, 32'h0);
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        wb_write(5'd3, 32'h55);

        // Opcode decode table
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1;
            instr = enc_i(op_tbl[k], 5'd1, 5'd6, 16'h8000);
            tick();
            idle();
            #1;
            check_eq($sformatf("ctrl_op%0h", op_tbl[k]), ctrl, ctrl_tbl[k]);
            check_eq($sformatf("valid_op%0h", op_tbl[k]), out_valid, 1);
        end
        check_eq("imm_sext", imm, 32'hFFFF8000);
        check_eq("i_data_a", data_a, 32'd7);

        // Taken BEQ r1==r2, pc 0x10 + 4
        valid = 1'b1; pc = 10'h10; instr = enc_i(6'h04, 5'd1, 5'd2, 16'd4);
        #1;
        check_eq("beq_flush", flush, 1);
        check_eq("beq_target", pc_src, 10'h14);
        check_eq("beq_pc_write", pc_write, 1);
        tick();
        idle();
        #1;
        check_eq("beq_flush_once", flush, 0);

        // BNE not taken, then taken through the forward mux with a negative offset
        valid = 1'b1; pc = 10'h20; instr = enc_i(6'h05, 5'd1, 5'd2, 16'hFFFE);
        #1;
        check_eq("bne_nt_flush", flush, 0);
        fwd_a = 1'b1; fwd_data = 32'd9;
        #1;
        check_eq("bne_fwd_flush", flush, 1);
        check_eq("bne_target", pc_src, 10'h01E);
        tick();
        idle();
        #1;
        check_eq("bne_imm", imm, 32'hFFFFFFFE);

        // Jump
        valid = 1'b1; instr = enc_j(26'h12AB);
        #1;
        check_eq("j_flush", flush, 1);
        check_eq("j_target", pc_src, 10'h2AB);
        tick();
        idle();

        // Hazard pattern with i_valid=0 is a plain bubble
        ex_load(5'd3); instr = enc_r(5'd3, 5'd1, 5'd4, 6'h20);
        #1;
        check_eq("nv_flush", flush, 0);
        tick();
        idle();
        #1;
        check_eq("nv_pc_write", pc_write, 1);
        check_eq("nv_valid", out_valid, 0);

        // Load-use: LW r3 in EX, ADD r4,r3,r1 in ID
        ex_load(5'd3); valid = 1'b1; instr = enc_r(5'd3, 5'd1, 5'd4, 6'h20);
        #1;
        check_eq("lu_detect_pc_write", pc_write, 1);
        tick();
        ex_idle();
        #1;
        check_eq("lu_stall_pc_write", pc_write, 0);
        check_eq("lu_stall_ifid", ifid_write, 0);
        check_eq("lu_stall_valid", out_valid, 0);
        check_eq("lu_stall_ctrl", ctrl, 0);
        tick();
        check_eq("lu_run_pc_write", pc_write, 1);
        tick();
        idle();
        #1;
        check_eq("lu_issue_valid", out_valid, 1);
        check_eq("lu_issue_ctrl", ctrl, 6'h22);
        check_eq("lu_issue_rd", rd, 4);
        check_eq("lu_issue_data_a", data_a, 32'h55);

        // Load into r0 never stalls
        ex_load(5'd0); valid = 1'b1; instr = enc_r(5'd0, 5'd0, 5'd8, 6'h20);
        tick();
        idle();
        #1;
        check_eq("ld_r0_pc_write", pc_write, 1);
        check_eq("ld_r0_valid", out_valid, 1);

        // Branch on load: two stall cycles, then resolution
        ex_load(5'd2); valid = 1'b1; pc = 10'h40; instr = enc_i(6'h05, 5'd2, 5'd0, 16'd3);
        #1;
        check_eq("bl_detect_flush", flush, 0);
        tick();
        ex_idle();
        #1;
        check_eq("bl_s2_pc_write", pc_write, 0);
        check_eq("bl_s2_valid", out_valid, 0);
        check_eq("bl_s2_flush", flush, 0);
        tick();
        fwd_a = 1'b1; fwd_data = 32'h99;
        #1;
        check_eq("bl_s1_pc_write", pc_write, 0);
        tick();
        check_eq("bl_run_flush", flush, 1);
        check_eq("bl_run_target", pc_src, 10'h43);
        check_eq("bl_run_pc_write", pc_write, 1);
        tick();
        idle();
        #1;
        check_eq("bl_issue_valid", out_valid, 1);

        // Branch on a non-load EX write: one stall cycle
        ex_reg_write = 1'b1; ex_dst = 5'd1;
        valid = 1'b1; pc = 10'h10; instr = enc_i(6'h04, 5'd1, 5'd2, 16'd4);
        #1;
        check_eq("ba_detect_flush", flush, 0);
        tick();
        ex_idle();
        #1;
        check_eq("ba_s1_pc_write", pc_write, 0);
        tick();
        check_eq("ba_run_flush", flush, 1);
        check_eq("ba_run_pc_write", pc_write, 1);
        tick();
        idle();

        // Reset in the middle of STALL2
        ex_load(5'd2); valid = 1'b1; instr = enc_i(6'h05, 5'd2, 5'd0, 16'd3);
        tick();
        idle();
        #1;
        check_eq("rs2_pc_write", pc_write, 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rs2_during_rst", pc_write, 1);
        #1;
        rst = 1'b0;
        tick();
        check_eq("rs2_after_pc_write", pc_write, 1);
        check_eq("rs2_after_valid", out_valid, 0);
        dbg_addr = 5'd1;
        #1;
        check_eq("rs2_rf_cleared", dbg_data, 32'h0);

        // HALT then ADDI
        valid = 1'b1; instr = {6'h3F, 26'h0};
        #1;
        check_eq("halt_no_flush", flush, 0);
        tick();
        instr = enc_i(6'h08, 5'd0, 5'd5, 16'd1);
        #1;
        check_eq("halt_set", halt, 1);
        check_eq("halt_bubble", out_valid, 0);
        tick();
        idle();
        #1;
        check_eq("halt_addi_valid", out_valid, 0);
        check_eq("halt_addi_ctrl", ctrl, 0);
        check_eq("halt_pc_write", pc_write, 0);
        tick();
        check_eq("halt_held", halt, 1);
        rst = 1'b1;
        #1;
        check_eq("halt_rst_clear", halt, 0);
        check_eq("halt_rst_pc_write", pc_write, 1);
        #1;
        rst = 1'b0;
        tick();
        check_eq("halt_after_rst", halt, 0);
        check_eq("halt_after_pc_write", pc_write, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
